// File: rtl/adc733_codec_port.sv
// Codec-side end of the adc733 serial port: divides clk down to SCLK, sends one framed
// sample word per frame on SDO and collects framed control words arriving on SDI.
module adc733_codec_port #(
    parameter int SCLK_DIV    = 2,
    parameter int WORD_BITS   = 16,
    parameter int FRAME_SCLKS = 64
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 SE,
    input  logic                 sync,
    output logic                 SCLK,
    output logic                 SDOFS,
    output logic                 SDO,
    input  logic                 SDIFS,
    input  logic                 SDI,
    input  logic [WORD_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_underrun,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_err
);
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int FC_W  = $clog2(FRAME_SCLKS);
    localparam int BC_W  = $clog2(WORD_BITS + 1);

    typedef enum logic [1:0] {T_IDLE, T_FS, T_SHIFT} tx_state_t;
    typedef enum logic {R_IDLE, R_SHIFT} rx_state_t;

    logic [DIV_W-1:0]     r_div;
    logic                 r_sclk;
    logic [FC_W-1:0]      r_fcnt;
    logic                 r_sync_pend;
    logic                 w_div_wrap, w_rise_en, w_fall_en;
    logic [FC_W-1:0]      w_fcnt_cur;

    tx_state_t            r_tx_state, w_tx_state_next;
    logic [WORD_BITS-1:0] r_tx_word, w_tx_word_next;
    logic [BC_W-1:0]      r_tx_cnt, w_tx_cnt_next;
    logic                 r_sdofs, w_sdofs_next, r_sdo, w_sdo_next;
    logic                 r_tx_ready, w_tx_ready_next, r_tx_underrun, w_tx_underrun_next;

    rx_state_t            r_rx_state, w_rx_state_next;
    logic [WORD_BITS-1:0] r_rx_shift, w_rx_shift_next, r_rx_data, w_rx_data_next;
    logic [BC_W-1:0]      r_rx_cnt, w_rx_cnt_next;
    logic                 r_rx_valid, w_rx_valid_next, r_rx_err, w_rx_err_next;

    assign w_div_wrap = (r_div == DIV_W'(SCLK_DIV - 1));
    assign w_rise_en  = SE && w_div_wrap && !r_sclk;
    assign w_fall_en  = SE && w_div_wrap && r_sclk;
    // A pending (or coincident) sync makes the upcoming rise the start of a new frame.
    assign w_fcnt_cur = (r_sync_pend || sync) ? '0 : r_fcnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_div       <= '0;
            r_sclk      <= 1'b0;
            r_fcnt      <= '0;
            r_sync_pend <= 1'b0;
        end else if (!SE) begin
            r_div       <= '0;
            r_sclk      <= 1'b0;
            r_fcnt      <= '0;
            r_sync_pend <= 1'b0;
        end else begin
            if (w_div_wrap) begin
                r_div  <= '0;
                r_sclk <= !r_sclk;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            if (w_rise_en) begin
                r_fcnt      <= (w_fcnt_cur == FC_W'(FRAME_SCLKS - 1)) ? '0 : w_fcnt_cur + FC_W'(1);
                r_sync_pend <= 1'b0;
            end else if (sync) begin
                r_sync_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        w_tx_state_next    = r_tx_state;
        w_tx_word_next     = r_tx_word;
        w_tx_cnt_next      = r_tx_cnt;
        w_sdofs_next       = r_sdofs;
        w_sdo_next         = r_sdo;
        w_tx_ready_next    = 1'b0;
        w_tx_underrun_next = 1'b0;
        if (!SE) begin
            w_tx_state_next = T_IDLE;
            w_sdofs_next    = 1'b0;
            w_sdo_next      = 1'b0;
        end else if (w_rise_en) begin
            if (w_fcnt_cur == '0) begin
                w_tx_state_next    = T_FS;
                w_sdofs_next       = 1'b1;
                w_sdo_next         = 1'b0;
                w_tx_cnt_next      = '0;
                w_tx_word_next     = tx_valid ? tx_data : '0;
                w_tx_ready_next    = tx_valid;
                w_tx_underrun_next = !tx_valid;
            end else begin
                case (r_tx_state)
                    T_FS: begin
                        w_tx_state_next = T_SHIFT;
                        w_sdofs_next    = 1'b0;
                        w_sdo_next      = r_tx_word[WORD_BITS-1];
                        w_tx_word_next  = r_tx_word << 1;
                        w_tx_cnt_next   = BC_W'(1);
                    end
                    T_SHIFT: begin
                        // r_tx_cnt counts bits already on the wire; the last one has now had its SCLK.
                        if (r_tx_cnt == BC_W'(WORD_BITS)) begin
                            w_tx_state_next = T_IDLE;
                            w_sdo_next      = 1'b0;
                        end else begin
                            w_sdo_next     = r_tx_word[WORD_BITS-1];
                            w_tx_word_next = r_tx_word << 1;
                            w_tx_cnt_next  = r_tx_cnt + BC_W'(1);
                        end
                    end
                    default: begin
                        w_sdofs_next = 1'b0;
                        w_sdo_next   = 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_shift_next = r_rx_shift;
        w_rx_data_next  = r_rx_data;
        w_rx_cnt_next   = r_rx_cnt;
        w_rx_valid_next = 1'b0;
        w_rx_err_next   = 1'b0;
        if (!SE) begin
            w_rx_err_next   = (r_rx_state == R_SHIFT);
            w_rx_state_next = R_IDLE;
        end else if (w_fall_en) begin
            case (r_rx_state)
                R_IDLE: begin
                    if (SDIFS) begin
                        w_rx_state_next = R_SHIFT;
                        w_rx_cnt_next   = '0;
                    end
                end
                default: begin
                    if (SDIFS) begin
                        w_rx_err_next = 1'b1;
                        w_rx_cnt_next = '0;
                    end else begin
                        w_rx_shift_next = {r_rx_shift[WORD_BITS-2:0], SDI};
                        if (r_rx_cnt == BC_W'(WORD_BITS - 1)) begin
                            w_rx_data_next  = {r_rx_shift[WORD_BITS-2:0], SDI};
                            w_rx_valid_next = 1'b1;
                            w_rx_state_next = R_IDLE;
                        end else begin
                            w_rx_cnt_next = r_rx_cnt + BC_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_tx_state    <= T_IDLE;
            r_tx_word     <= '0;
            r_tx_cnt      <= '0;
            r_sdofs       <= 1'b0;
            r_sdo         <= 1'b0;
            r_tx_ready    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_rx_state    <= R_IDLE;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_rx_cnt      <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_err      <= 1'b0;
        end else begin
            r_tx_state    <= w_tx_state_next;
            r_tx_word     <= w_tx_word_next;
            r_tx_cnt      <= w_tx_cnt_next;
            r_sdofs       <= w_sdofs_next;
            r_sdo         <= w_sdo_next;
            r_tx_ready    <= w_tx_ready_next;
            r_tx_underrun <= w_tx_underrun_next;
            r_rx_state    <= w_rx_state_next;
            r_rx_shift    <= w_rx_shift_next;
            r_rx_data     <= w_rx_data_next;
            r_rx_cnt      <= w_rx_cnt_next;
            r_rx_valid    <= w_rx_valid_next;
            r_rx_err      <= w_rx_err_next;
        end
    end

    assign SCLK        = r_sclk;
    assign SDOFS       = r_sdofs;
    assign SDO         = r_sdo;
    assign tx_ready    = r_tx_ready;
    assign tx_underrun = r_tx_underrun;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_err      = r_rx_err;
endmodule

// File: tb/tb_adc733_codec_port.sv
// Bench for adc733_codec_port: acts as the host, sampling SDO on falling SCLK and driving
// SDIFS/SDI after rising SCLK, checked against a frame/word model built from the port rules.
module tb_adc733_codec_port;
    localparam int DIV = 2;
    localparam int W   = 16;
    localparam int FR  = 64;

    logic         clk = 1'b0, rst_l = 1'b0, SE = 1'b0, sync = 1'b0;
    logic         SDIFS = 1'b0, SDI = 1'b0, tx_valid = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         SCLK, SDOFS, SDO, tx_ready, tx_underrun, rx_valid, rx_err;
    logic [W-1:0] rx_data;

    int           n_checks = 0, n_fail = 0;
    int           n_ready = 0, n_under = 0, n_rxv = 0, n_rxe = 0;
    logic [W-1:0] last_rx = '0;
    bit           prev_sclk = 1'b0, rose = 1'b0, fell = 1'b0;

    adc733_codec_port #(.SCLK_DIV(DIV), .WORD_BITS(W), .FRAME_SCLKS(FR)) dut (
        .clk(clk), .rst_l(rst_l), .SE(SE), .sync(sync), .SCLK(SCLK), .SDOFS(SDOFS),
        .SDO(SDO), .SDIFS(SDIFS), .SDI(SDI), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_ready)    n_ready++;
        if (tx_underrun) n_under++;
        if (rx_err)      n_rxe++;
        if (rx_valid) begin
            n_rxv++;
            last_rx = rx_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rose = SCLK && !prev_sclk;
        fell = !SCLK && prev_sclk;
        prev_sclk = SCLK;
    endtask

    task automatic wait_edge(input bit want_rise, output bit ok);
        int g = 0;
        ok = 1'b0;
        while (!ok && g < 4 * DIV + 4) begin
            tick();
            g++;
            ok = want_rise ? rose : fell;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sclk_edge: no %s within %0d clks", want_rise ? "rise" : "fall", g);
        end
    endtask

    task automatic start_port();
        SE = 1'b0;
        repeat (4) tick();
        SE = 1'b1;
    endtask

    task automatic test_reset();
        rst_l = 1'b0; SE = 1'b1; tx_valid = 1'b1; tx_data = 16'hA5C3;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks += 2;
            if ({SCLK, SDOFS, SDO, tx_ready, tx_underrun, rx_valid, rx_err} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d: got %b expected 0000000", i,
                         {SCLK, SDOFS, SDO, tx_ready, tx_underrun, rx_valid, rx_err});
            end
            if (rx_data !== '0) begin
                n_fail++;
                $display("FAIL reset_rx_data cyc=%0d: got %h expected 0000", i, rx_data);
            end
        end
        rst_l = 1'b1;
    endtask

    // Frame k is expected to carry exp_w[k]: SDOFS at falling edge 64k, word bits at 64k+1..64k+16.
    task automatic test_tx(input int nfalls, input bit rnd, input logic [W-1:0] d0, input bit v0);
        logic [W-1:0] exp_w [0:7];
        bit           exp_v [0:7];
        int           r0, u0, nstart, er, eu, ph, fr;
        bit           ok, e_fs, e_do;
        tx_data  = rnd ? W'($urandom) : d0;
        tx_valid = rnd ? 1'($urandom_range(0, 1)) : v0;
        exp_v[0] = tx_valid;
        exp_w[0] = tx_valid ? tx_data : '0;
        start_port();
        r0 = n_ready; u0 = n_under; ok = 1'b1;
        for (int i = 0; i < nfalls && ok; i++) begin
            wait_edge(1'b0, ok);
            if (ok) begin
                ph = i % FR; fr = i / FR;
                e_fs = (ph == 0);
                e_do = (ph >= 1 && ph <= W) ? exp_w[fr][W-ph] : 1'b0;
                n_checks += 2;
                if (SDOFS !== e_fs) begin
                    n_fail++;
                    $display("FAIL tx_sdofs fall=%0d: got %b expected %b", i, SDOFS, e_fs);
                end
                if (SDO !== e_do) begin
                    n_fail++;
                    $display("FAIL tx_sdo fall=%0d: got %b expected %b", i, SDO, e_do);
                end
                if (ph == 40) begin
                    if (rnd) begin
                        tx_data  = W'($urandom);
                        tx_valid = 1'($urandom_range(0, 1));
                    end
                    exp_v[fr+1] = tx_valid;
                    exp_w[fr+1] = tx_valid ? tx_data : '0;
                end
            end
        end
        nstart = (nfalls - 1) / FR + 1;
        er = 0; eu = 0;
        for (int f = 0; f < nstart; f++) begin
            if (exp_v[f]) er++;
            else          eu++;
        end
        n_checks += 2;
        if (n_ready - r0 !== er) begin
            n_fail++;
            $display("FAIL tx_ready_count: got %0d expected %0d", n_ready - r0, er);
        end
        if (n_under - u0 !== eu) begin
            n_fail++;
            $display("FAIL tx_underrun_count: got %0d expected %0d", n_under - u0, eu);
        end
    endtask

    // Host sends SDIFS, optionally err_after stray bits plus a second SDIFS, then the word.
    task automatic test_rx(input logic [W-1:0] word, input int err_after);
        bit fs_a [0:47];
        bit d_a  [0:47];
        int n = 0, rv0, re0;
        bit ok;
        start_port();
        SDIFS = 1'b0; SDI = 1'b0;
        rv0 = n_rxv; re0 = n_rxe;
        fs_a[n] = 1'b1; d_a[n] = 1'b0; n++;
        if (err_after >= 0) begin
            for (int i = 0; i < err_after; i++) begin
                fs_a[n] = 1'b0; d_a[n] = 1'($urandom); n++;
            end
            fs_a[n] = 1'b1; d_a[n] = 1'b0; n++;
        end
        for (int b = W - 1; b >= 0; b--) begin
            fs_a[n] = 1'b0; d_a[n] = word[b]; n++;
        end
        for (int i = 0; i < 2; i++) begin
            fs_a[n] = 1'b0; d_a[n] = 1'b0; n++;
        end
        for (int i = 0; i < n; i++) begin
            wait_edge(1'b1, ok);
            SDIFS = fs_a[i];
            SDI   = d_a[i];
        end
        wait_edge(1'b0, ok);
        n_checks += 3;
        if (n_rxv - rv0 !== 1) begin
            n_fail++;
            $display("FAIL rx_valid_count word=%h: got %0d expected 1", word, n_rxv - rv0);
        end
        if (last_rx !== word) begin
            n_fail++;
            $display("FAIL rx_data: got %h expected %h", last_rx, word);
        end
        if (n_rxe - re0 !== ((err_after >= 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL rx_err_count word=%h: got %0d expected %0d", word, n_rxe - re0,
                     (err_after >= 0) ? 1 : 0);
        end
    endtask

    task automatic test_sync();
        logic [W-1:0] d2;
        int           r0;
        bit           ok, e_fs, e_do;
        tx_valid = 1'b1;
        tx_data  = W'($urandom);
        start_port();
        for (int i = 0; i < 9; i++) wait_edge(1'b0, ok);
        d2 = W'($urandom);
        tx_data = d2;
        r0 = n_ready;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int i = 0; i <= FR; i++) begin
            wait_edge(1'b0, ok);
            e_fs = (i == 0 || i == FR);
            e_do = (i >= 1 && i <= W) ? d2[W-i] : 1'b0;
            n_checks += 2;
            if (SDOFS !== e_fs) begin
                n_fail++;
                $display("FAIL sync_sdofs fall=%0d: got %b expected %b", i, SDOFS, e_fs);
            end
            if (SDO !== e_do) begin
                n_fail++;
                $display("FAIL sync_sdo fall=%0d: got %b expected %b", i, SDO, e_do);
            end
        end
        n_checks++;
        if (n_ready - r0 !== 2) begin
            n_fail++;
            $display("FAIL sync_ready_count: got %0d expected 2", n_ready - r0);
        end
    endtask

    task automatic test_se_drop();
        int rv0, re0;
        bit ok;
        start_port();
        SDIFS = 1'b0; SDI = 1'b0;
        rv0 = n_rxv; re0 = n_rxe;
        wait_edge(1'b1, ok);
        SDIFS = 1'b1;
        for (int b = 0; b < 5; b++) begin
            wait_edge(1'b1, ok);
            SDIFS = 1'b0;
            SDI   = 1'($urandom);
        end
        SE = 1'b0;
        for (int g = 0; g < DIV && SCLK; g++) tick();
        n_checks += 2;
        if (SCLK !== 1'b0) begin
            n_fail++;
            $display("FAIL se_drop_sclk: got %b expected 0", SCLK);
        end
        if ({SDOFS, SDO} !== 2'b00) begin
            n_fail++;
            $display("FAIL se_drop_sdo: got %b expected 00", {SDOFS, SDO});
        end
        repeat (4) tick();
        n_checks += 2;
        if (n_rxe - re0 !== 1) begin
            n_fail++;
            $display("FAIL se_drop_rx_err: got %0d expected 1", n_rxe - re0);
        end
        if (n_rxv - rv0 !== 0) begin
            n_fail++;
            $display("FAIL se_drop_rx_valid: got %0d expected 0", n_rxv - rv0);
        end
        SE = 1'b1;
    endtask

    task automatic test_async_reset();
        bit ok;
        tx_valid = 1'b1;
        tx_data  = 16'hFFFF;
        start_port();
        for (int i = 0; i < 4; i++) wait_edge(1'b0, ok);
        wait_edge(1'b1, ok);
        #2;
        rst_l = 1'b0;
        #1;
        n_checks += 2;
        if ({SCLK, SDOFS, SDO} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %b expected 000", {SCLK, SDOFS, SDO});
        end
        if (rx_data !== '0) begin
            n_fail++;
            $display("FAIL async_reset_rx_data: got %h expected 0000", rx_data);
        end
        tick();
        rst_l = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_tx(80, 1'b0, 16'hA5C3, 1'b1);
        test_tx(80, 1'b0, 16'h5A5A, 1'b0);
        test_tx(FR * 4 + 20, 1'b1, '0, 1'b0);
        test_rx(16'h8001, -1);
        test_rx(16'h1234, 7);
        for (int k = 0; k < 4; k++) test_rx(W'($urandom), (k % 2 == 1) ? int'($urandom_range(1, 14)) : -1);
        test_sync();
        test_se_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
